pile_score: RTL and testbench

Game-control stage wrapped around the gravity/drawing block. Owns the three column stack heights, generates the one-cycle fall `pulse`, picks the column of each new brick, and keeps the BCD score, level and game state. It consumes the gravity block's landing pulses (`plus_*`), `aligne` and `perdu`, and drives back its `hauteur*`, `col`, `pulse` and a one-cycle restart.

---
 rtl/pile_score_if.sv | 18 +
 rtl/pile_score.sv | 109 ++++++++++
 tb/tb_pile_score.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pile_score_if.sv
// pile_score_if: control/status bundle between the game-control stage and the gravity block
interface pile_score_if;
  logic start, plus_gauche, plus_centre, plus_droite, aligne, perdu;
  logic [2:0] hauteur_gauche, hauteur_centre, hauteur_droite;
  logic [1:0] col;
  logic pulse, raz_chute;
  logic [15:0] score;
  logic [3:0] niveau;
  logic [1:0] etat;
  modport master (
    output start, plus_gauche, plus_centre, plus_droite, aligne, perdu,
    input hauteur_gauche, hauteur_centre, hauteur_droite, col, pulse, raz_chute, score, niveau, etat
  );
  modport slave (
    input start, plus_gauche, plus_centre, plus_droite, aligne, perdu,
    output hauteur_gauche, hauteur_centre, hauteur_droite, col, pulse, raz_chute, score, niveau, etat
  );
endinterface

// File: rtl/pile_score.sv
// pile_score: game control (stack heights, fall tick, brick column, BCD score, level, state); LEVEL_SPEEDUP_EN enables level-driven speedup
module pile_score #(
  parameter int TICKS_INIT = 25000000,
  parameter int TICKS_STEP = 2000000,
  parameter int TICKS_MIN = 5000000,
  parameter int LINES_PER_LEVEL = 5
) (
  input logic clk,
  input logic reset,
  pile_score_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
  state_t state;
  logic [7:0] lfsr;
  logic [31:0] cnt, p_cur;
  logic enter, active, wrap, landed;
  logic [1:0] lfsr_col;
  function automatic logic [2:0] step_h(input logic [2:0] h, input logic inc, input logic dec);
    logic [2:0] t;
    t = (dec && h != 3'd0) ? h - 3'd1 : h;
    return (inc && t != 3'd7) ? t + 3'd1 : t;
  endfunction
  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic c;
    r = s;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction
  if (TICKS_INIT < 2 || TICKS_MIN < 2 || TICKS_STEP < 0 || LINES_PER_LEVEL < 1 || LINES_PER_LEVEL > 256) begin : g_bad_cfg
    $error("pile_score: invalid tick or level configuration");
  end
  assign enter = bus.start && state != PLAY;
  assign active = state == PLAY && !bus.perdu;
  assign wrap = cnt == p_cur - 32'd1;
  assign landed = bus.plus_gauche || bus.plus_centre || bus.plus_droite;
  assign lfsr_col = 2'(lfsr % 8'd3);
  assign bus.etat = state;
  // game state, tick counter, column pick, heights and score; perdu blocks every update in its own cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lfsr <= 8'hA5;
      cnt <= '0;
      bus.pulse <= 1'b0;
      bus.raz_chute <= 1'b0;
      bus.col <= 2'd0;
      bus.hauteur_gauche <= 3'd0;
      bus.hauteur_centre <= 3'd0;
      bus.hauteur_droite <= 3'd0;
      bus.score <= 16'h0000;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      bus.raz_chute <= enter;
      bus.pulse <= active && wrap;
      if (enter) begin
        state <= PLAY;
        cnt <= '0;
        bus.col <= lfsr_col;
        bus.hauteur_gauche <= 3'd0;
        bus.hauteur_centre <= 3'd0;
        bus.hauteur_droite <= 3'd0;
        bus.score <= 16'h0000;
      end else if (state == PLAY) begin
        cnt <= wrap ? '0 : cnt + 32'd1;
        if (bus.perdu) state <= OVER;
        if (active) begin
          bus.hauteur_gauche <= step_h(bus.hauteur_gauche, bus.plus_gauche, bus.aligne);
          bus.hauteur_centre <= step_h(bus.hauteur_centre, bus.plus_centre, bus.aligne);
          bus.hauteur_droite <= step_h(bus.hauteur_droite, bus.plus_droite, bus.aligne);
          if (bus.aligne) bus.score <= bcd_inc(bus.score);
          if (landed) bus.col <= lfsr_col;
        end
      end
    end
  end
`ifdef LEVEL_SPEEDUP_EN
  logic [31:0] step_total, p_next;
  logic [7:0] lines;
  assign step_total = 32'(bus.niveau) * 32'(TICKS_STEP);
  assign p_next = (32'(TICKS_INIT) > step_total && 32'(TICKS_INIT) - step_total > 32'(TICKS_MIN)) ? 32'(TICKS_INIT) - step_total : 32'(TICKS_MIN);
  // line counter, saturating level and the period that is reloaded only when the tick counter wraps
  always_ff @(posedge clk) begin
    if (reset || enter) begin
      lines <= '0;
      bus.niveau <= 4'd0;
      p_cur <= 32'(TICKS_INIT);
    end else if (state == PLAY) begin
      if (wrap) p_cur <= p_next;
      if (active && bus.aligne) begin
        lines <= (lines == 8'(LINES_PER_LEVEL - 1)) ? '0 : lines + 8'd1;
        if (lines == 8'(LINES_PER_LEVEL - 1) && bus.niveau != 4'd15) bus.niveau <= bus.niveau + 4'd1;
      end
    end
  end
`else
  assign bus.niveau = 4'd0;
  assign p_cur = 32'(TICKS_INIT);
`endif
endmodule

// File: tb/tb_pile_score.sv
// tb_pile_score: vector table, hand sequences and random stimulus against a behavioural game model
module tb_pile_score;
  localparam int TI = 8, TS = 2, TM = 4, LPL = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, errors = 0;
  pile_score_if bus();
  pile_score #(.TICKS_INIT(TI), .TICKS_STEP(TS), .TICKS_MIN(TM), .LINES_PER_LEVEL(LPL)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int m_state, m_score, m_level, m_lines, m_cnt, m_p, m_col;
  int m_h[3];
  logic m_pulse, m_raz;
  logic [7:0] m_lfsr;
  typedef struct {
    logic rs, st;
    logic [2:0] pl;
    logic al, pe;
    logic [1:0] etat;
    logic [2:0] g, c, d;
    logic [15:0] score;
  } vec_t;
  vec_t tbl[16];
  function automatic int period();
`ifdef LEVEL_SPEEDUP_EN
    return (TI - m_level * TS < TM) ? TM : TI - m_level * TS;
`else
    return TI;
`endif
  endfunction
  function automatic logic [15:0] to_bcd(int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction
  task automatic model_step(input logic rs, st, input logic [2:0] pl, input logic al, pe);
    logic [7:0] old;
    old = m_lfsr;
    if (rs) begin
      m_state = 0; m_h = '{0, 0, 0}; m_score = 0; m_level = 0; m_lines = 0;
      m_cnt = 0; m_p = TI; m_col = 0; m_pulse = 0; m_raz = 0; m_lfsr = 8'hA5;
      return;
    end
    m_lfsr = {old[6:0], old[7] ^ old[5] ^ old[4] ^ old[3]};
    m_raz = st && m_state != 1;
    m_pulse = m_state == 1 && !pe && m_cnt == m_p - 1;
    if (m_raz) begin
      m_state = 1; m_h = '{0, 0, 0}; m_score = 0; m_level = 0; m_lines = 0;
      m_cnt = 0; m_p = TI; m_col = int'(old) % 3;
    end else if (m_state == 1) begin
      if (m_cnt == m_p - 1) begin
        m_cnt = 0;
        m_p = period();
      end else m_cnt++;
      if (pe) m_state = 2;
      else begin
        for (int k = 0; k < 3; k++) begin
          if (al && m_h[k] > 0) m_h[k]--;
          if (pl[k] && m_h[k] < 7) m_h[k]++;
        end
        if (al) begin
          m_score = (m_score + 1) % 10000;
`ifdef LEVEL_SPEEDUP_EN
          m_lines++;
          if (m_lines == LPL) begin
            m_lines = 0;
            if (m_level < 15) m_level++;
          end
`endif
        end
        if (pl != 3'b000) m_col = int'(old) % 3;
      end
    end
  endtask
  function automatic logic [63:0] dut_vec();
    return {29'd0, bus.etat, bus.hauteur_gauche, bus.hauteur_centre, bus.hauteur_droite, bus.col, bus.pulse, bus.raz_chute, bus.score, bus.niveau};
  endfunction
  function automatic logic [63:0] model_vec();
    return {29'd0, 2'(m_state), 3'(m_h[0]), 3'(m_h[1]), 3'(m_h[2]), 2'(m_col), m_pulse, m_raz, to_bcd(m_score), 4'(m_level)};
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic rs, st, input logic [2:0] pl, input logic al, pe);
    reset = rs;
    bus.start = st;
    bus.plus_gauche = pl[0];
    bus.plus_centre = pl[1];
    bus.plus_droite = pl[2];
    bus.aligne = al;
    bus.perdu = pe;
    @(posedge clk);
    model_step(rs, st, pl, al, pe);
    #1;
    check("model", dut_vec(), model_vec());
  endtask
  task automatic idle();
    cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
  endtask
  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      idle();
      n++;
    end while (bus.pulse !== 1'b1 && n < 100);
    check("pulse within budget", 64'(bus.pulse), 64'd1);
  endtask
  initial begin
    int n, idle_pulses;
    int q[$];
    bus.start = 1'b0; bus.plus_gauche = 1'b0; bus.plus_centre = 1'b0;
    bus.plus_droite = 1'b0; bus.aligne = 1'b0; bus.perdu = 1'b0;
    tbl = '{
      '{1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000},
      '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000},
      '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd1, 3'd0, 3'd0, 3'd0, 16'h0000},
      '{1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 2'd1, 3'd1, 3'd0, 3'd0, 16'h0000},
      '{1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 2'd1, 3'd2, 3'd0, 3'd0, 16'h0000},
      '{1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 2'd1, 3'd3, 3'd0, 3'd0, 16'h0000},
      '{1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 2'd1, 3'd3, 3'd1, 3'd0, 16'h0000},
      '{1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 2'd1, 3'd3, 3'd1, 3'd1, 16'h0000},
      '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 2'd1, 3'd2, 3'd0, 3'd0, 16'h0001},
      '{1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 2'd1, 3'd1, 3'd1, 3'd0, 16'h0002},
      '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd1, 3'd1, 3'd1, 3'd0, 16'h0002},
      '{1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 2'd2, 3'd1, 3'd1, 3'd0, 16'h0002},
      '{1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 2'd2, 3'd1, 3'd1, 3'd0, 16'h0002},
      '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd1, 3'd0, 3'd0, 3'd0, 16'h0000},
      '{1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 2'd1, 3'd1, 3'd0, 3'd1, 16'h0000},
      '{1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000}
    };
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].rs, tbl[i].st, tbl[i].pl, tbl[i].al, tbl[i].pe);
      check($sformatf("vec%0d etat", i), 64'(bus.etat), 64'(tbl[i].etat));
      check($sformatf("vec%0d heights", i), {55'd0, bus.hauteur_gauche, bus.hauteur_centre, bus.hauteur_droite}, {55'd0, tbl[i].g, tbl[i].c, tbl[i].d});
      check($sformatf("vec%0d score", i), 64'(bus.score), 64'(tbl[i].score));
    end
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    idle_pulses = 0;
    for (int i = 0; i < 9; i++) begin
      idle();
      idle_pulses += int'(bus.pulse);
    end
    check("no pulse before start", 64'(idle_pulses), 64'd0);
    cyc(1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
    check("first play raz", {62'd0, bus.etat, bus.raz_chute}, 64'b011);
    for (int r = 1; r <= 30; r++) begin
      idle();
      if (bus.pulse) q.push_back(r);
    end
    check("pulse count", 64'(q.size()), 64'd3);
    for (int i = 0; i < 3 && i < q.size(); i++) check($sformatf("pulse%0d offset", i), 64'(q[i]), 64'(8 * (i + 1)));
    repeat (2) cyc(1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    wait_pulse(n);
    wait_pulse(n);
    wait_pulse(n);
`ifdef LEVEL_SPEEDUP_EN
    check("level after 2 lines", 64'(bus.niveau), 64'd1);
    check("spacing level 1", 64'(n), 64'd6);
`else
    check("level held", 64'(bus.niveau), 64'd0);
    check("spacing fixed", 64'(n), 64'(TI));
`endif
    repeat (14) cyc(1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    wait_pulse(n);
    wait_pulse(n);
    wait_pulse(n);
`ifdef LEVEL_SPEEDUP_EN
    check("level after 16 lines", 64'(bus.niveau), 64'd8);
    check("spacing at floor", 64'(n), 64'(TM));
`else
    check("level held", 64'(bus.niveau), 64'd0);
    check("spacing fixed", 64'(n), 64'(TI));
`endif
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
    repeat (9999) cyc(1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    check("score 9999", 64'(bus.score), 64'h9999);
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    check("score wrap", 64'(bus.score), 64'h0000);
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
    check("perdu priority", {60'd0, bus.etat, bus.pulse, bus.raz_chute}, 64'b1000);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 3'b111, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
    check("heights 5/2/4", {55'd0, bus.hauteur_gauche, bus.hauteur_centre, bus.hauteur_droite}, {55'd0, 3'd5, 3'd2, 3'd4});
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    check("mid-play reset", dut_vec(), 64'd0);
    repeat (5) idle();
    cyc(1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0, 3'($urandom_range(0, 7) & ($urandom_range(0, 3) == 0 ? 7 : 0)),
          $urandom_range(0, 5) == 0, $urandom_range(0, 79) == 0);
      check("col range", 64'(bus.col <= 2'd2), 64'd1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
